// File: rtl/fifo_burst_writer_if.sv
// Write-port bundle between a burst writer (master) and its controller/FIFO side (slave).
interface fifo_burst_writer_if #(
    parameter int DATESIZE = 8,
    parameter int LENSIZE  = 8
);
    logic                start;
    logic [LENSIZE-1:0]  burst_len;
    logic [DATESIZE-1:0] seed;
    logic                mode;
    logic                abort;
    logic                wfull;
    logic                almost_full;
    logic                winc;
    logic [DATESIZE-1:0] wdata;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [LENSIZE-1:0]  words_written;
    logic [15:0]         stall_cnt;

    modport master (
        input  start, burst_len, seed, mode, abort, wfull, almost_full,
        output winc, wdata, busy, done, aborted, words_written, stall_cnt
    );

    modport slave (
        output start, burst_len, seed, mode, abort, wfull, almost_full,
        input  winc, wdata, busy, done, aborted, words_written, stall_cnt
    );
endinterface

// File: rtl/fifo_burst_writer.sv
// Burst pattern generator for an async FIFO write port: increment or LFSR data,
// throttled by full/almost-full, with abort and per-burst word/stall counters.
module fifo_burst_writer #(
    parameter int DATESIZE   = 8,
    parameter int LENSIZE    = 8,
    parameter int USE_ALMOST = 1
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    fifo_burst_writer_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATESIZE-1:0] wdata_q, wdata_d;
    logic [LENSIZE-1:0]  len_q, len_d;
    logic [LENSIZE-1:0]  words_q, words_d;
    logic [15:0]         stall_q, stall_d;
    logic                mode_q, mode_d;
    logic                aborted_q, aborted_d;

    logic                throttle;
    logic                winc;
    logic                last_word;
    logic [DATESIZE-1:0] next_data;
    logic [DATESIZE-1:0] seed_load;

    // winc stays a direct function of state and flags so a full FIFO blocks the write in the same cycle
    assign throttle  = bus.wfull || ((USE_ALMOST != 0) && bus.almost_full);
    assign winc      = (state_q == WRITE) && !throttle && !bus.abort;
    assign last_word = (LENSIZE'(words_q + LENSIZE'(1)) == len_q);
    assign next_data = mode_q ? {wdata_q[DATESIZE-2:0], wdata_q[7] ^ wdata_q[5] ^ wdata_q[4] ^ wdata_q[3]}
                              : DATESIZE'(wdata_q + DATESIZE'(1));
    assign seed_load = (bus.mode && (bus.seed == '0)) ? DATESIZE'(1) : bus.seed;

    always_comb begin
        state_d   = state_q;
        wdata_d   = wdata_q;
        len_d     = len_q;
        words_d   = words_q;
        stall_d   = stall_q;
        mode_d    = mode_q;
        aborted_d = aborted_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    words_d   = '0;
                    stall_d   = '0;
                    aborted_d = 1'b0;
                    if (bus.burst_len != '0) begin
                        state_d = WRITE;
                        len_d   = bus.burst_len;
                        mode_d  = bus.mode;
                        wdata_d = seed_load;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (winc) begin
                    words_d = LENSIZE'(words_q + LENSIZE'(1));
                    wdata_d = next_data;
                    if (last_word) begin
                        state_d   = DONE;
                        aborted_d = 1'b0;
                    end
                end else if (bus.abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q   <= IDLE;
            wdata_q   <= '0;
            len_q     <= '0;
            words_q   <= '0;
            stall_q   <= '0;
            mode_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdata_q   <= wdata_d;
            len_q     <= len_d;
            words_q   <= words_d;
            stall_q   <= stall_d;
            mode_q    <= mode_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.winc          = winc;
    assign bus.wdata         = wdata_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.aborted       = aborted_q;
    assign bus.words_written = words_q;
    assign bus.stall_cnt     = stall_q;
endmodule
